// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the round-robin bus sequencer and related arbiters.
package bus_arb_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_XFER = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                  we;
    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_DATA_W-1:0] wdata;
  } bus_req_t;

  // Round-robin successor of idx among n requesters.
  function automatic int rr_next(int idx, int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/bus_rr_sequencer_if.sv
// Single-outstanding valid/ready bus; the follower returns read data alongside ready.
interface bus_rr_sequencer_if #(
  parameter int ADDR_WIDTH = bus_arb_pkg::BUS_ADDR_W,
  parameter int DATA_WIDTH = bus_arb_pkg::BUS_DATA_W
);
  logic                  valid;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ready;

  modport master (output valid, we, addr, wdata, input rdata, ready);
  modport slave  (input valid, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first request at or above the pointer, wrapping to bit 0.
module rr_pick #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [N-1:0] w_hi;
  logic [N-1:0] w_sel;

  always_comb begin
    w_hi = '0;
    for (int i = 0; i < N; i++) begin
      w_hi[i] = i_req[i] && (i >= int'(i_ptr));
    end
    // Nothing at/above the pointer means the search wraps to the lowest request.
    w_sel = (|w_hi) ? w_hi : i_req;
  end

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = |i_req;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_sel[i]) begin
        o_gnt    = '0;
        o_gnt[i] = 1'b1;
        o_idx    = IW'(i);
      end
    end
  end

endmodule

// File: rtl/bus_rr_sequencer.sv
// Round-robin sharing of one bus master port among N_REQ requesters, one transfer at a time.
// Accept at T, bus_valid from T+1, response one cycle after ready; timeout returns an error.
module bus_rr_sequencer
  import bus_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int ADDR_WIDTH = BUS_ADDR_W,
  parameter int DATA_WIDTH = BUS_DATA_W,
  parameter int TIMEOUT    = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            i_req_valid,
  input  logic [N_REQ-1:0]            i_req_we,
  input  logic [N_REQ*ADDR_WIDTH-1:0] i_req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] i_req_wdata,
  output logic [N_REQ-1:0]            o_req_ready,
  output logic [N_REQ-1:0]            o_resp_valid,
  output logic [DATA_WIDTH-1:0]       o_resp_rdata,
  output logic                        o_resp_err,
  output logic                        o_busy,
  bus_rr_sequencer_if.master          m_bus
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);

  localparam logic [1:0] S_IDLE = ARB_IDLE;
  localparam logic [1:0] S_XFER = ARB_XFER;
  localparam logic [1:0] S_DONE = ARB_DONE;

  logic [1:0]            r_state;
  logic [PW-1:0]         r_ptr;
  logic [PW-1:0]         r_owner;
  logic [CW-1:0]         r_cnt;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;

  logic [N_REQ-1:0]      w_gnt;
  logic [PW-1:0]         w_idx;
  logic                  w_any;
  logic                  w_sel_we;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;

  rr_pick #(.N(N_REQ)) u_pick (
    .i_req (i_req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // One-hot grant steers the winner's request fields.
  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_we    = i_req_we[i];
        w_sel_addr  = i_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_wdata = i_req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_owner <= w_idx;
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_cnt   <= '0;
            r_state <= S_XFER;
          end
        end
        S_XFER: begin
          // Ready on the final timeout cycle still completes the transfer.
          if (m_bus.ready) begin
            r_rdata <= r_we ? '0 : m_bus.rdata;
            r_err   <= 1'b0;
            r_state <= S_DONE;
          end else if (r_cnt == TO_MAX) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_ptr   <= PW'(rr_next(int'(r_owner), N_REQ));
          r_cnt   <= '0;
          r_rdata <= '0;
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_resp_valid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      o_resp_valid[i] = (r_state == S_DONE) && (r_owner == PW'(i));
    end
  end

  assign o_req_ready  = (r_state == S_IDLE) ? w_gnt : '0;
  assign o_resp_rdata = r_rdata;
  assign o_resp_err   = r_err;
  assign o_busy       = (r_state != S_IDLE);

  assign m_bus.valid  = (r_state == S_XFER);
  assign m_bus.we     = r_we;
  assign m_bus.addr   = r_addr;
  assign m_bus.wdata  = r_wdata;

endmodule

// File: tb/tb_bus_rr_sequencer.sv
// Scoreboard bench for bus_rr_sequencer: directed transfers, round-robin order, timeout, reset.
module tb_bus_rr_sequencer;
  import bus_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 8;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid, req_we, req_ready, resp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   resp_rdata;
  logic            resp_err, busy;

  bus_rr_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bif ();

  bus_rr_sequencer #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_req_valid  (req_valid),
    .i_req_we     (req_we),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .o_req_ready  (req_ready),
    .o_resp_valid (resp_valid),
    .o_resp_rdata (resp_rdata),
    .o_resp_err   (resp_err),
    .o_busy       (busy),
    .m_bus        (bif)
  );

  typedef struct {int idx; logic [DW-1:0] rdata; logic err; int lat;} resp_exp_t;
  typedef struct {bus_req_t req; int vlen;} bus_exp_t;

  int        q_grant[$];
  resp_exp_t q_resp[$];
  bus_exp_t  q_bus[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: DUT output with empty scoreboard (cycle %0d)", name, cyc);
  endtask

  // Bus follower: ready after f_delay cycles of valid, or never when f_mode=1.
  int            f_mode = 0;
  int            f_delay = 1;
  logic [DW-1:0] f_rdata = '0;
  initial begin
    int vcnt;
    vcnt = 0;
    bif.ready = 1'b0;
    bif.rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (bif.valid && !rst) vcnt++;
      else vcnt = 0;
      bif.ready = (f_mode == 0) && bif.valid && (vcnt >= f_delay);
      bif.rdata = bif.ready ? f_rdata : 8'hEE;
    end
  end

  // Requester driver: holds req_valid[i] until every issued request has been accepted.
  int            req_total[N];
  int            granted[N];
  logic [N-1:0]  g_seen;
  initial begin
    req_valid = '0;
    for (int i = 0; i < N; i++) granted[i] = 0;
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < N; i++) begin
        if (g_seen[i]) granted[i]++;
        req_valid[i] = (granted[i] < req_total[i]);
      end
    end
  end

  // Monitor / scoreboard, sampling on the falling edge.
  initial begin
    logic         in_v;
    int           vlen;
    int           last_gnt;
    bus_req_t     cap;
    logic [N-1:0] pend_prev;
    int           e;
    bus_exp_t     be;
    resp_exp_t    re;
    in_v = 1'b0; vlen = 0; last_gnt = 0; cap = '0; pend_prev = '0; g_seen = '0;
    forever begin
      @(negedge clk);
      g_seen = rst ? '0 : req_ready;
      if (rst) begin
        in_v = 1'b0;
        vlen = 0;
        pend_prev = '0;
      end else begin
        assert ((pend_prev & ~req_valid) == '0)
          else $error("protocol: req_valid dropped before accept (%b -> %b)", pend_prev, req_valid);
        pend_prev = req_valid & ~req_ready;

        if (req_ready != '0) begin
          chk("gnt_only_in_idle", busy, 0);
          if (q_grant.size() == 0) unexpected("gnt");
          else begin
            e = q_grant.pop_front();
            chk("gnt_idx", req_ready, 64'(1) << e);
          end
          last_gnt = cyc;
        end

        if (bif.valid) begin
          if (!in_v) begin
            in_v = 1'b1;
            vlen = 0;
            cap = '{we: bif.we, addr: bif.addr, wdata: bif.wdata};
          end else begin
            chk("bus_stable", {bif.we, bif.addr, bif.wdata}, cap);
          end
          vlen++;
        end else if (in_v) begin
          in_v = 1'b0;
          if (q_bus.size() == 0) unexpected("bus");
          else begin
            be = q_bus.pop_front();
            chk("bus_we", cap.we, be.req.we);
            chk("bus_addr", cap.addr, be.req.addr);
            chk("bus_wdata", cap.wdata, be.req.wdata);
            chk("bus_valid_len", vlen, be.vlen);
          end
        end

        if (resp_valid != '0) begin
          if (q_resp.size() == 0) unexpected("resp");
          else begin
            re = q_resp.pop_front();
            chk("resp_idx", resp_valid, 64'(1) << re.idx);
            chk("resp_rdata", resp_rdata, re.rdata);
            chk("resp_err", resp_err, re.err);
            chk("resp_latency", cyc - last_gnt, re.lat);
          end
        end
      end
    end
  end

  task automatic issue(int i, logic we, logic [AW-1:0] a, logic [DW-1:0] d);
    req_we[i] = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    req_total[i]++;
  endtask

  task automatic exp_xfer(int i, logic we, logic [AW-1:0] a, logic [DW-1:0] d,
                          int vlen, logic [DW-1:0] rd, logic err);
    bus_exp_t  b;
    resp_exp_t r;
    b.req = '{we: we, addr: a, wdata: d};
    b.vlen = vlen;
    r = '{idx: i, rdata: rd, err: err, lat: vlen + 1};
    q_grant.push_back(i);
    q_bus.push_back(b);
    q_resp.push_back(r);
  endtask

  task automatic drain(string name);
    int k;
    k = 0;
    while ((q_grant.size() != 0 || q_bus.size() != 0 || q_resp.size() != 0 ||
            busy || req_valid != '0) && k < 60) begin
      @(posedge clk);
      k++;
    end
    chk(name, (k < 60), 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: no finish within 300000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    rst = 1'b1;
    req_we = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < N; i++) req_total[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bus_valid", bif.valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_bus_addr", bif.addr, 0);
    chk("rst_bus_we", bif.we, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // All four requesting, ready immediately: order 0,1,2,3,0 (pointer starts at 0).
    f_mode = 0; f_delay = 1; f_rdata = 8'hA5;
    issue(0, 1'b0, 32'h100, 8'h00);
    issue(1, 1'b0, 32'h104, 8'h00);
    issue(2, 1'b1, 32'h108, 8'h22);
    issue(3, 1'b0, 32'h10C, 8'h00);
    issue(0, 1'b0, 32'h100, 8'h00);
    exp_xfer(0, 1'b0, 32'h100, 8'h00, 1, 8'hA5, 1'b0);
    exp_xfer(1, 1'b0, 32'h104, 8'h00, 1, 8'hA5, 1'b0);
    exp_xfer(2, 1'b1, 32'h108, 8'h22, 1, 8'h00, 1'b0);
    exp_xfer(3, 1'b0, 32'h10C, 8'h00, 1, 8'hA5, 1'b0);
    exp_xfer(0, 1'b0, 32'h100, 8'h00, 1, 8'hA5, 1'b0);
    drain("drain_all_four");

    // Single read from requester 1, ready after 3 cycles of valid.
    f_delay = 3; f_rdata = 8'h5A;
    issue(1, 1'b0, 32'h40, 8'h00);
    exp_xfer(1, 1'b0, 32'h40, 8'h00, 3, 8'h5A, 1'b0);
    drain("drain_single_read");

    // Write accepted the same cycle valid rises; read data from the follower is ignored.
    f_delay = 1; f_rdata = 8'h5F;
    issue(2, 1'b1, 32'h80, 8'hC3);
    exp_xfer(2, 1'b1, 32'h80, 8'hC3, 1, 8'h00, 1'b0);
    drain("drain_write");

    // Pointer now 3 with requesters 3 and 0 pending: 3 first, then wrap to 0.
    f_delay = 2; f_rdata = 8'h77;
    issue(0, 1'b0, 32'h200, 8'h00);
    issue(3, 1'b0, 32'h300, 8'h00);
    exp_xfer(3, 1'b0, 32'h300, 8'h00, 2, 8'h77, 1'b0);
    exp_xfer(0, 1'b0, 32'h200, 8'h00, 2, 8'h77, 1'b0);
    drain("drain_wrap");

    // Timeout: ready never comes, valid held TIMEOUT+1 cycles, error response.
    f_mode = 1;
    issue(1, 1'b0, 32'h44, 8'h00);
    exp_xfer(1, 1'b0, 32'h44, 8'h00, TO + 1, 8'h00, 1'b1);
    drain("drain_timeout");
    f_mode = 0; f_delay = 2; f_rdata = 8'h3C;
    issue(3, 1'b0, 32'h48, 8'h00);
    exp_xfer(3, 1'b0, 32'h48, 8'h00, 2, 8'h3C, 1'b0);
    drain("drain_after_timeout");
    f_delay = 1; f_rdata = 8'h12;
    issue(0, 1'b1, 32'h4C, 8'h9E);
    exp_xfer(0, 1'b1, 32'h4C, 8'h9E, 1, 8'h00, 1'b0);
    drain("drain_ptr_to_1");

    // Reset mid-transfer: requester 2 wins (pointer 1), then reset during XFER.
    f_mode = 1;
    issue(2, 1'b0, 32'h60, 8'h00);
    q_grant.push_back(2);
    k = 0;
    while (!bif.valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("rst_xfer_valid_seen", bif.valid, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_xfer_bus_valid", bif.valid, 0);
    chk("rst_xfer_busy", busy, 0);
    chk("rst_xfer_resp_valid", resp_valid, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // After reset the pointer is 0 again: requester 0 beats requester 3.
    f_mode = 0; f_delay = 1; f_rdata = 8'h99;
    issue(0, 1'b0, 32'h400, 8'h00);
    issue(3, 1'b0, 32'h430, 8'h00);
    exp_xfer(0, 1'b0, 32'h400, 8'h00, 1, 8'h99, 1'b0);
    exp_xfer(3, 1'b0, 32'h430, 8'h00, 1, 8'h99, 1'b0);
    drain("drain_after_reset");

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
